// File: rtl/alu_cmd_seq_pkg.sv
// Shared definitions for the ALU command sequencer: select codes, the arithmetic-op
// helper, FSM state encoding and the default datapath width.
package alu_cmd_seq_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_NOT  = 4'b0010;
    localparam logic [3:0] SEL_NOR  = 4'b0011;
    localparam logic [3:0] SEL_XOR  = 4'b0100;
    localparam logic [3:0] SEL_NAND = 4'b0101;
    localparam logic [3:0] SEL_ADD  = 4'b0110;
    localparam logic [3:0] SEL_SUB  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Only ADD and SUB produce a carry worth saving for a chain.
    function automatic logic is_arith(input logic [3:0] sel);
        return (sel == SEL_ADD) || (sel == SEL_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_seq_stats.sv
// Operation and arithmetic-overflow counters for the ALU command sequencer
// (present only when ALU_CMD_SEQ_STATS_EN is defined).
module alu_cmd_seq_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture,
    input  logic        arith_ovf,
    output logic [31:0] op_count,
    output logic [15:0] ovf_count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count  <= '0;
            ovf_count <= '0;
        end else if (capture) begin
            op_count <= op_count + 32'd1;
            // Overflow count sticks at all-ones instead of wrapping.
            if (arith_ovf && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-issue stage ahead of the 32-bit ALU: registers operands, captures the
// result and flags, and carries carry/zero across chained ops. Optional counters: ALU_CMD_SEQ_STATS_EN.
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// EXEC  | ALU inputs driven, result captured at the next edge
// DONE  | result held until res_ready
module alu_cmd_sequencer
    import alu_cmd_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic             cmd_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_y,
    output logic             res_cout,
    output logic             res_negative,
    output logic             res_zero,
    output logic             res_overflow,
`ifdef ALU_CMD_SEQ_STATS_EN
    output logic [31:0]      op_count,
    output logic [15:0]      ovf_count,
`endif
    output logic             carry_q
);

    seq_state_t state;
    logic       chain_q;
    logic       zero_acc;
    logic       zero_next;

    // A chained result is zero only if every word of the chain was zero.
    always_comb begin
        zero_next = alu_zero;
        if (chain_q) begin
            zero_next = alu_zero & zero_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_sel      <= '0;
            alu_cin      <= 1'b0;
            chain_q      <= 1'b0;
            res_valid    <= 1'b0;
            res_y        <= '0;
            res_cout     <= 1'b0;
            res_negative <= 1'b0;
            res_zero     <= 1'b0;
            res_overflow <= 1'b0;
            carry_q      <= 1'b0;
            zero_acc     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        alu_sel   <= cmd_sel;
                        alu_cin   <= cmd_chain ? carry_q : cmd_cin;
                        chain_q   <= cmd_chain;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    res_y        <= alu_y;
                    res_cout     <= alu_cout;
                    res_negative <= alu_negative;
                    res_overflow <= alu_overflow;
                    res_zero     <= zero_next;
                    res_valid    <= 1'b1;
                    zero_acc     <= zero_next;
                    if (is_arith(alu_sel)) begin
                        carry_q <= alu_cout;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_CMD_SEQ_STATS_EN
    alu_cmd_seq_stats u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (state == EXEC),
        .arith_ovf (is_arith(alu_sel) & alu_overflow),
        .op_count  (op_count),
        .ovf_count (ovf_count)
    );
`endif

endmodule
